// File: rtl/hp_fifo.sv
// hp_fifo: host-to-parasite Tube data buffer, DEPTH entries of DATA_WIDTH bits.
// Single clock (h_phi2), synchronous active-low reset (h_rst_b), synchronous
// flush. p_data shows the head entry, or the last popped entry when empty.
// Optional build macro HP_FIFO_NMI_EN adds the registered p_nmi output, which
// is high whenever the occupancy is at least NMI_LEVEL.
module hp_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 24,
  parameter int AVAIL_LEVEL = 1,
  parameter int NMI_LEVEL   = 1,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  h_phi2,
  input  logic                  h_rst_b,
  input  logic                  h_selectData,
  input  logic                  h_we_b,
  input  logic [DATA_WIDTH-1:0] h_data,
  input  logic                  h_flush,
  input  logic                  p_selectData,
  input  logic                  p_rdnw,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  p_data_available,
  output logic                  h_full,
  output logic [CW-1:0]         p_count,
`ifdef HP_FIFO_NMI_EN
  output logic                  p_nmi,
`endif
  output logic                  h_overflow
);

  // Pointer width; a single-entry FIFO still needs a 1-bit pointer.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [CW-1:0]         count_r;
  logic [DATA_WIDTH-1:0] last_r;

  logic          push_req_s;
  logic          pop_req_s;
  logic          empty_s;
  logic          full_s;
  logic          push_ok_s;
  logic          pop_ok_s;
  logic [CW-1:0] next_count_s;

  // Pointers wrap explicitly at DEPTH-1, so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PW'(DEPTH - 1)) begin
      r = {PW{1'b0}};
    end else begin
      r = p + PW'(1);
    end
    return r;
  endfunction

  // Decode requests and decide which of them the FIFO accepts this cycle.
  always_comb begin
    push_req_s = h_selectData & ~h_we_b;
    pop_req_s  = p_selectData & p_rdnw;
    empty_s    = (count_r == {CW{1'b0}});
    full_s     = (count_r == CW'(DEPTH));
    // A pop on an empty FIFO is ignored; a push at full only fits if a pop
    // frees the head slot in the same cycle.
    pop_ok_s   = pop_req_s & ~empty_s;
    push_ok_s  = push_req_s & (~full_s | pop_ok_s);
    if (push_ok_s && !pop_ok_s) begin
      next_count_s = count_r + CW'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      next_count_s = count_r - CW'(1);
    end else begin
      next_count_s = count_r;
    end
  end

  // Control state: pointers, occupancy, last popped value and sticky overflow.
  always_ff @(posedge h_phi2) begin
    if (!h_rst_b) begin
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      last_r     <= {DATA_WIDTH{1'b0}};
      h_overflow <= 1'b0;
    end else if (h_flush) begin
      // Flush empties the FIFO but keeps last_r so p_data stays stable.
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      h_overflow <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
        last_r   <= mem[rd_ptr_r];
      end
      if (push_req_s && !push_ok_s) begin
        h_overflow <= 1'b1;
      end
      count_r <= next_count_s;
    end
  end

  // Storage write; the array is deliberately not reset.
  always_ff @(posedge h_phi2) begin
    if (h_rst_b && !h_flush && push_ok_s) begin
      mem[wr_ptr_r] <= h_data;
    end
  end

  // Read data and level flags derived from the registered occupancy.
  always_comb begin
    if (empty_s) begin
      p_data = last_r;
    end else begin
      p_data = mem[rd_ptr_r];
    end
    p_data_available = (count_r >= CW'(AVAIL_LEVEL));
    h_full           = full_s;
    p_count          = count_r;
  end

`ifdef HP_FIFO_NMI_EN
  // NMI follows the occupancy the FIFO will hold after this edge.
  always_ff @(posedge h_phi2) begin
    if (!h_rst_b) begin
      p_nmi <= 1'b0;
    end else if (h_flush) begin
      p_nmi <= 1'b0;
    end else begin
      p_nmi <= (next_count_s >= CW'(NMI_LEVEL));
    end
  end
`endif

endmodule

// File: tb/tb_hp_fifo.sv
// Self-checking bench for hp_fifo: a 24-deep instance and a 3-deep instance
// (AVAIL_LEVEL=2, NMI_LEVEL=2), each tracked by a queue-based reference model.
module tb_hp_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst_b;
    bit         flush;
    bit         hsel;
    bit         we_b;
    bit         psel;
    bit         rdnw;
    logic [7:0] d;
  } in_t;

  typedef struct {
    in_t        v;
    logic [7:0] e_data;
    bit         e_av;
    bit         e_full;
    int         e_cnt;
    bit         e_ovf;
  } vec_t;

  // Instance 0 pins (DEPTH=24)
  logic       rst_b0, hsel0, we_b0, flush0, psel0, rdnw0;
  logic [7:0] d0, pd0;
  logic       av0, full0, ovf0, nmi0;
  logic [4:0] cnt0;
  // Instance 1 pins (DEPTH=3)
  logic       rst_b1, hsel1, we_b1, flush1, psel1, rdnw1;
  logic [7:0] d1, pd1;
  logic       av1, full1, ovf1, nmi1;
  logic [1:0] cnt1;

  hp_fifo #(.DATA_WIDTH(8), .DEPTH(24), .AVAIL_LEVEL(1), .NMI_LEVEL(1)) u0 (
    .h_phi2(clk), .h_rst_b(rst_b0), .h_selectData(hsel0), .h_we_b(we_b0),
    .h_data(d0), .h_flush(flush0), .p_selectData(psel0), .p_rdnw(rdnw0),
    .p_data(pd0), .p_data_available(av0), .h_full(full0), .p_count(cnt0),
`ifdef HP_FIFO_NMI_EN
    .p_nmi(nmi0),
`endif
    .h_overflow(ovf0)
  );

  hp_fifo #(.DATA_WIDTH(8), .DEPTH(3), .AVAIL_LEVEL(2), .NMI_LEVEL(2)) u1 (
    .h_phi2(clk), .h_rst_b(rst_b1), .h_selectData(hsel1), .h_we_b(we_b1),
    .h_data(d1), .h_flush(flush1), .p_selectData(psel1), .p_rdnw(rdnw1),
    .p_data(pd1), .p_data_available(av1), .h_full(full1), .p_count(cnt1),
`ifdef HP_FIFO_NMI_EN
    .p_nmi(nmi1),
`endif
    .h_overflow(ovf1)
  );

`ifndef HP_FIFO_NMI_EN
  assign nmi0 = 1'b0;
  assign nmi1 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] last0 = 8'h00, last1 = 8'h00;
  bit         movf0 = 1'b0, movf1 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input bit push, input bit pop, input logic [7:0] d);
    in_t v;
    v.rst_b = 1'b1; v.flush = 1'b0;
    v.hsel = push;  v.we_b = ~push;
    v.psel = pop;   v.rdnw = pop;
    v.d = d;
    return v;
  endfunction

  function automatic in_t mk_rst();
    in_t v = mk(1'b0, 1'b0, 8'h00);
    v.rst_b = 1'b0;
    return v;
  endfunction

  function automatic in_t mk_flush(input bit push, input bit pop, input logic [7:0] d);
    in_t v = mk(push, pop, d);
    v.flush = 1'b1;
    return v;
  endfunction

  // FIFO behaviour expressed on a queue: a pop takes the head first (if any),
  // then a push goes in if there is room.
  task automatic mstep(inout logic [7:0] q[$], inout logic [7:0] last, inout bit ovf,
                       input int depth, input in_t v);
    if (!v.rst_b) begin
      q.delete(); last = 8'h00; ovf = 1'b0;
    end else if (v.flush) begin
      q.delete(); ovf = 1'b0;
    end else begin
      if (v.psel && v.rdnw && q.size() > 0) last = q.pop_front();
      if (v.hsel && !v.we_b) begin
        if (q.size() < depth) q.push_back(v.d);
        else ovf = 1'b1;
      end
    end
  endtask

  task automatic check_inst(input string tag, input logic [7:0] q[$], input logic [7:0] last,
                            input bit ovf, input int depth, input int avl,
                            input logic [7:0] a_d, input logic a_av, input logic a_full,
                            input logic [31:0] a_cnt, input logic a_ovf);
    logic [7:0] ed;
    ed = (q.size() != 0) ? q[0] : last;
    chk({tag, ".p_data"}, 32'(a_d), 32'(ed));
    chk({tag, ".avail"}, 32'(a_av), 32'(q.size() >= avl));
    chk({tag, ".full"}, 32'(a_full), 32'(q.size() == depth));
    chk({tag, ".count"}, a_cnt, 32'(q.size()));
    chk({tag, ".overflow"}, 32'(a_ovf), 32'(ovf));
  endtask

  task automatic apply(input in_t a, input in_t b);
    rst_b0 = a.rst_b; flush0 = a.flush; hsel0 = a.hsel; we_b0 = a.we_b;
    psel0 = a.psel; rdnw0 = a.rdnw; d0 = a.d;
    rst_b1 = b.rst_b; flush1 = b.flush; hsel1 = b.hsel; we_b1 = b.we_b;
    psel1 = b.psel; rdnw1 = b.rdnw; d1 = b.d;
    @(posedge clk);
    mstep(q0, last0, movf0, 24, a);
    mstep(q1, last1, movf1, 3, b);
    #1;
    check_inst("u0", q0, last0, movf0, 24, 1, pd0, av0, full0, 32'(cnt0), ovf0);
    check_inst("u1", q1, last1, movf1, 3, 2, pd1, av1, full1, 32'(cnt1), ovf1);
`ifdef HP_FIFO_NMI_EN
    chk("u0.nmi", 32'(nmi0), 32'(q0.size() >= 1));
    chk("u1.nmi", 32'(nmi1), 32'(q1.size() >= 2));
`endif
  endtask

  in_t  idle;
  vec_t tbl[15];

  initial begin
    idle = mk(1'b0, 1'b0, 8'h00);

    // Table: reset, empty pop, simultaneous push/pop at empty, flush cases.
    tbl[0]  = '{mk_rst(),                      8'h00, 0, 0, 0, 0};
    tbl[1]  = '{mk_rst(),                      8'h00, 0, 0, 0, 0};
    tbl[2]  = '{mk(0, 1, 8'h00),               8'h00, 0, 0, 0, 0};
    tbl[3]  = '{mk(1, 1, 8'h55),               8'h55, 1, 0, 1, 0};
    tbl[4]  = '{mk(1, 0, 8'h66),               8'h55, 1, 0, 2, 0};
    tbl[5]  = '{mk(0, 1, 8'h00),               8'h66, 1, 0, 1, 0};
    tbl[6]  = '{mk(0, 1, 8'h00),               8'h66, 0, 0, 0, 0};
    tbl[7]  = '{mk(0, 1, 8'h00),               8'h66, 0, 0, 0, 0};
    tbl[8]  = '{mk_flush(1, 0, 8'h12),         8'h66, 0, 0, 0, 0};
    tbl[9]  = '{mk(1, 0, 8'h21),               8'h21, 1, 0, 1, 0};
    tbl[10] = '{mk_flush(0, 1, 8'h00),         8'h66, 0, 0, 0, 0};
    tbl[11] = '{mk(0, 0, 8'h99),               8'h66, 0, 0, 0, 0};
    tbl[12] = '{mk(1, 0, 8'h33),               8'h33, 1, 0, 1, 0};
    tbl[13] = '{mk(0, 0, 8'h00),               8'h33, 1, 0, 1, 0};
    tbl[14] = '{mk_rst(),                      8'h00, 0, 0, 0, 0};
    // Non-push host access and non-read parasite access must be inert.
    tbl[11].v.hsel = 1'b1;
    tbl[13].v.psel = 1'b1;

    apply(mk_rst(), mk_rst());
    apply(mk_rst(), mk_rst());
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].v, idle);
      chk($sformatf("tbl%0d.p_data", i), 32'(pd0), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d.avail", i), 32'(av0), 32'(tbl[i].e_av));
      chk($sformatf("tbl%0d.full", i), 32'(full0), 32'(tbl[i].e_full));
      chk($sformatf("tbl%0d.count", i), 32'(cnt0), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d.ovf", i), 32'(ovf0), 32'(tbl[i].e_ovf));
    end

    // Ordering and overflow on the 24-deep instance.
    for (int i = 1; i <= 24; i++) begin
      apply(mk(1, 0, 8'(i)), idle);
      chk("fill.count", 32'(cnt0), 32'(i));
    end
    chk("fill.full", 32'(full0), 32'd1);
    apply(mk(1, 0, 8'hAA), idle);
    chk("ovf.flag", 32'(ovf0), 32'd1);
    chk("ovf.count", 32'(cnt0), 32'd24);
    for (int i = 1; i <= 24; i++) begin
      chk("drain.head", 32'(pd0), 32'(i));
      apply(mk(0, 1, 8'h00), idle);
    end
    chk("drain.count", 32'(cnt0), 32'd0);
    chk("drain.hold", 32'(pd0), 32'h18);
    apply(mk_flush(0, 0, 8'h00), idle);
    chk("flush.ovf", 32'(ovf0), 32'd0);
    chk("flush.last", 32'(pd0), 32'h18);

    // Simultaneous push/pop at full.
    for (int i = 1; i <= 24; i++) apply(mk(1, 0, 8'(i)), idle);
    apply(mk(1, 1, 8'h77), idle);
    chk("fullpp.count", 32'(cnt0), 32'd24);
    chk("fullpp.ovf", 32'(ovf0), 32'd0);
    chk("fullpp.head", 32'(pd0), 32'd2);
    for (int i = 0; i < 24; i++) begin
      chk("fullpp.seq", 32'(pd0), (i == 23) ? 32'h77 : 32'(i + 2));
      apply(mk(0, 1, 8'h00), idle);
    end
    chk("fullpp.last", 32'(pd0), 32'h77);

    // Wrap on the 3-deep instance, plus NMI threshold at 2.
    apply(idle, mk_flush(0, 0, 8'h00));
    apply(idle, mk(1, 0, 8'h10));
    chk("w.avail1", 32'(av1), 32'd0);
`ifdef HP_FIFO_NMI_EN
    chk("w.nmi1", 32'(nmi1), 32'd0);
`endif
    apply(idle, mk(1, 0, 8'h11));
    chk("w.avail2", 32'(av1), 32'd1);
`ifdef HP_FIFO_NMI_EN
    chk("w.nmi2", 32'(nmi1), 32'd1);
`endif
    for (int r = 0; r < 10; r++) begin
      chk("w.head", 32'(pd1), (r == 0) ? 32'h10 : (r == 1) ? 32'h11 : 32'(8'h20 + r - 2));
      apply(idle, mk(1, 1, 8'(8'h20 + r)));
      chk("w.count", 32'(cnt1), 32'd2);
    end
    apply(idle, mk(0, 1, 8'h00));
    chk("w.pop", 32'(cnt1), 32'd1);
`ifdef HP_FIFO_NMI_EN
    chk("w.nmi3", 32'(nmi1), 32'd0);
`endif

    // Randomised traffic on both instances against the queue model.
    for (int n = 0; n < 3000; n++) begin
      in_t a, b;
      a.rst_b = ($urandom_range(0, 299) != 0); a.flush = ($urandom_range(0, 59) == 0);
      a.hsel = $urandom_range(0, 1); a.we_b = ($urandom_range(0, 3) == 0);
      a.psel = ($urandom_range(0, 2) == 0); a.rdnw = ($urandom_range(0, 4) != 0);
      a.d = 8'($urandom);
      b.rst_b = ($urandom_range(0, 299) != 0); b.flush = ($urandom_range(0, 59) == 0);
      b.hsel = $urandom_range(0, 1); b.we_b = ($urandom_range(0, 3) == 0);
      b.psel = $urandom_range(0, 1); b.rdnw = ($urandom_range(0, 4) != 0);
      b.d = 8'($urandom);
      apply(a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
